// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  // Width of the event counters (retry_count, lock_loss_count).
  localparam int COUNT_W = 8;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // Width of the shared cycle counter: $clog2 of the largest cycle parameter,
  // never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the chain; the last stage is the safe output.
  // NOTE: every flop here is reset so locked_s reads 0 until real samples arrive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-on / lock supervisor: pulses the PLL reset, waits for a stable lock,
// releases downstream reset, retries on timeout or lock loss, and latches a
// fault after MAX_RETRIES consecutive lock timeouts.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES         = 2,
  parameter int MAX_RETRIES         = 8
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               locked,
  input  logic               clear_fault,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [COUNT_W-1:0] retry_count,
  output logic [COUNT_W-1:0] lock_loss_count
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CW-1:0]      RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]      STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] RETRY_LIMIT  = COUNT_W'(MAX_RETRIES);

  logic               locked_s;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [COUNT_W-1:0] retry_q, retry_d;
  logic [COUNT_W-1:0] llc_q, llc_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               lock_lost_q, lock_lost_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_locked_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  // Next-state, counter and registered-output decode.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    llc_d       = llc_q;
    lock_lost_d = 1'b0;

    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        // Lock drop outranks the terminal count.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = RESET_PLL;
          lock_lost_d = 1'b1;
          if (llc_q != '1) llc_d = llc_q + 1'b1;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    // The counter restarts on every state entry and only runs in timed states,
    // so it can never wrap.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {RESET_PLL, WAIT_LOCK, STABLE}) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  // State, counters and outputs all update on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      llc_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      llc_q       <= llc_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign lock_lost       = lock_lost_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;

endmodule
